// File: rtl/frame_test_scheduler.sv
// Frame test scheduler: launches a sweep of generator frames, waits for the
// checker verdict (or a timeout) and accumulates frame/error statistics.
module frame_test_scheduler #(
  parameter int PAYLOAD_MAX_SIZE = 1500,
  parameter int START_CYCLES     = 2,
  parameter int GAP_CYCLES       = 20,
  parameter int TIMEOUT_CYCLES   = 4096
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_abort,
  input  logic [15:0] i_num_frames,
  input  logic [15:0] i_len_min,
  input  logic [15:0] i_len_max,
  input  logic [15:0] i_len_step,
  input  logic [7:0]  i_mode,
  input  logic        i_rx_done,
  input  logic [6:0]  i_err_vec,
  output logic        o_start,
  output logic [15:0] o_payload_length,
  output logic [7:0]  o_mode,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_aborted,
  output logic        o_timeout,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_err_cnt
);

  localparam int START_W = (START_CYCLES   > 1) ? $clog2(START_CYCLES)   : 1;
  localparam int GAP_W   = (GAP_CYCLES     > 1) ? $clog2(GAP_CYCLES)     : 1;
  localparam int WAIT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [START_W-1:0] START_LAST = START_W'(START_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]        LEN_CAP    = 16'(PAYLOAD_MAX_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_DONE,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state;
  logic               en_p0;
  logic               rx_done_p0;
  logic [START_W-1:0] start_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  logic [15:0] cfg_num;
  logic [15:0] cfg_min;
  logic [15:0] cfg_max;
  logic [15:0] cfg_step;
  logic [7:0]  cfg_mode;

  logic en_rise;
  logic rx_rise;
  logic in_run;

  function automatic logic [15:0] clamp_len(input logic [15:0] x);
    if (x == 16'd0)
      clamp_len = 16'd1;
    else if (x > LEN_CAP)
      clamp_len = LEN_CAP;
    else
      clamp_len = x;
  endfunction

  // The sum is held in 17 bits so a large step can never alias back into range.
  function automatic logic [15:0] next_len(input logic [15:0] cur,
                                           input logic [15:0] lmin,
                                           input logic [15:0] lmax,
                                           input logic [15:0] step);
    logic [16:0] sum;
    logic [15:0] lo;
    logic [15:0] hi;
    lo  = clamp_len(lmin);
    hi  = clamp_len(lmax);
    sum = {1'b0, cur} + {1'b0, step};
    if (step == 16'd0 || lmin > lmax)
      next_len = lo;
    else if (sum > {1'b0, hi})
      next_len = lo;
    else
      next_len = sum[15:0];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    sat_inc = (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  assign en_rise = i_enable & ~en_p0;
  assign rx_rise = i_rx_done & ~rx_done_p0;
  assign in_run  = (state == S_LAUNCH) || (state == S_WAIT_DONE) || (state == S_GAP);

  // Run configuration is captured once per run and only read while running.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && en_rise) begin
      cfg_num  <= i_num_frames;
      cfg_min  <= i_len_min;
      cfg_max  <= i_len_max;
      cfg_step <= i_len_step;
      cfg_mode <= i_mode;
    end
  end

  // en_p0 resets high so an enable held through reset is not taken as a new edge.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state            <= S_IDLE;
      en_p0            <= 1'b1;
      rx_done_p0       <= 1'b0;
      start_cnt        <= '0;
      wait_cnt         <= '0;
      gap_cnt          <= '0;
      o_start          <= 1'b0;
      o_payload_length <= 16'd0;
      o_mode           <= 8'd0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_aborted        <= 1'b0;
      o_timeout        <= 1'b0;
      o_frame_cnt      <= 16'd0;
      o_err_cnt        <= 16'd0;
    end else begin
      en_p0      <= i_enable;
      rx_done_p0 <= i_rx_done;
      if (in_run && i_abort) begin
        o_start   <= 1'b0;
        o_aborted <= 1'b1;
        o_busy    <= 1'b0;
        o_done    <= 1'b1;
        state     <= S_DONE;
      end else begin
        case (state)
          S_IDLE: begin
            if (en_rise) begin
              o_frame_cnt      <= 16'd0;
              o_err_cnt        <= 16'd0;
              o_timeout        <= 1'b0;
              o_aborted        <= 1'b0;
              o_payload_length <= clamp_len(i_len_min);
              o_mode           <= i_mode;
              o_start          <= 1'b1;
              o_busy           <= 1'b1;
              start_cnt        <= '0;
              state            <= S_LAUNCH;
            end
          end
          S_LAUNCH: begin
            if (start_cnt == START_LAST) begin
              o_start  <= 1'b0;
              wait_cnt <= '0;
              state    <= S_WAIT_DONE;
            end else begin
              start_cnt <= start_cnt + 1'b1;
            end
          end
          S_WAIT_DONE: begin
            if (rx_rise) begin
              o_frame_cnt <= sat_inc(o_frame_cnt);
              if (|i_err_vec)
                o_err_cnt <= sat_inc(o_err_cnt);
              gap_cnt <= '0;
              state   <= S_GAP;
            end else if (wait_cnt == WAIT_LAST) begin
              o_frame_cnt <= sat_inc(o_frame_cnt);
              o_err_cnt   <= sat_inc(o_err_cnt);
              o_timeout   <= 1'b1;
              gap_cnt     <= '0;
              state       <= S_GAP;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          S_GAP: begin
            if (gap_cnt == GAP_LAST) begin
              if (cfg_num != 16'd0 && o_frame_cnt == cfg_num) begin
                o_busy <= 1'b0;
                o_done <= 1'b1;
                state  <= S_DONE;
              end else begin
                o_payload_length <= next_len(o_payload_length, cfg_min, cfg_max, cfg_step);
                o_mode           <= cfg_mode;
                o_start          <= 1'b1;
                start_cnt        <= '0;
                state            <= S_LAUNCH;
              end
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          S_DONE: begin
            if (!i_enable) begin
              o_done <= 1'b0;
              state  <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
